// File: rtl/counter_preset_ctrl.sv
// Job controller for a loadable up counter: presets it, waits for the limit,
// reloads for each remaining run and pulses done when the job completes.
module counter_preset_ctrl #(
  parameter int WIDTH  = 4,
  parameter int RUNS_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [WIDTH-1:0]  preset,
  input  logic [WIDTH-1:0]  limit,
  input  logic [RUNS_W-1:0] num_runs,
  input  logic [WIDTH-1:0]  q_in,
  output logic              load,
  output logic [WIDTH-1:0]  d,
  output logic              busy,
  output logic              done,
  output logic [RUNS_W-1:0] run_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  lim_r;
  logic [RUNS_W-1:0] runs_r;
  logic              hit;
  logic [RUNS_W:0]   next_cnt;

  assign hit      = (q_in == lim_r);
  assign next_cnt = {1'b0, run_cnt} + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      load    <= 1'b0;
      d       <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      run_cnt <= '0;
      lim_r   <= '0;
      runs_r  <= '0;
    end else if (abort && state != IDLE) begin
      // run_cnt keeps its partial value so software can see progress
      state <= IDLE;
      load  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && !abort) begin
            d       <= preset;
            lim_r   <= limit;
            runs_r  <= (num_runs == '0) ? RUNS_W'(1) : num_runs;
            run_cnt <= '0;
            load    <= 1'b1;
            busy    <= 1'b1;
            state   <= LOAD;
          end
        end
        LOAD: begin
          load  <= 1'b0;
          state <= RUN;
        end
        RUN: begin
          if (hit) begin
            run_cnt <= next_cnt[RUNS_W-1:0];
            if (next_cnt < {1'b0, runs_r}) begin
              load  <= 1'b1;
              state <= LOAD;
            end else begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_preset_ctrl.sv
// Bench for counter_preset_ctrl: a counter model closes the loop and each
// job is checked cycle by cycle against a trace built from job arithmetic.
module tb_counter_preset_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic [3:0] preset;
  logic [3:0] limit;
  logic [3:0] num_runs;
  logic [3:0] q;
  logic       load;
  logic [3:0] d;
  logic       busy;
  logic       done;
  logic [3:0] run_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic       ld;
    logic       bz;
    logic       dn;
    logic [3:0] rc;
    logic [3:0] dd;
  } obs_t;

  counter_preset_ctrl #(.WIDTH(4), .RUNS_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .preset(preset), .limit(limit), .num_runs(num_runs),
    .q_in(q), .load(load), .d(d), .busy(busy), .done(done),
    .run_cnt(run_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // the loadable counter being controlled
  initial q = 4'd0;
  always @(posedge clk) q <= load ? d : q + 4'd1;

  function automatic obs_t mk(input bit l, input bit b, input bit dn,
                              input int rc, input int dv);
    obs_t o;
    o.ld = l;
    o.bz = b;
    o.dn = dn;
    o.rc = 4'(rc);
    o.dd = 4'(dv);
    return o;
  endfunction

  // A run is one LOAD cycle plus (limit-preset mod 16)+1 RUN cycles.
  task automatic run_job(input int p, input int l, input int n,
                         input int abort_at, input bit noise,
                         output int busy_cycles, output int done_idx);
    obs_t tr[$];
    obs_t a;
    obs_t e;
    int nr;
    int len;
    nr  = (n == 0) ? 1 : n;
    len = ((l - p) & 15) + 1;
    for (int r = 0; r < nr; r++) begin
      tr.push_back(mk(1, 1, 0, r, p));
      for (int k = 0; k < len; k++) tr.push_back(mk(0, 1, 0, r, p));
    end
    tr.push_back(mk(0, 0, 1, nr, p));
    tr.push_back(mk(0, 0, 0, nr, p));
    if (abort_at >= 0 && abort_at < tr.size() - 1) begin
      e = tr[abort_at];
      while (tr.size() > abort_at + 1) void'(tr.pop_back());
      tr.push_back(mk(0, 0, 0, int'(e.rc), p));
    end
    @(negedge clk);
    preset   = 4'(p);
    limit    = 4'(l);
    num_runs = 4'(n);
    start    = 1'b1;
    abort    = 1'b0;
    busy_cycles = 0;
    done_idx    = -1;
    for (int i = 0; i < tr.size(); i++) begin
      @(negedge clk);
      a = {load, busy, done, run_cnt, d};
      total++;
      if (a !== tr[i]) begin
        bad++;
        $display("FAIL job p=%0d l=%0d n=%0d cyc=%0d got ld=%b bz=%b dn=%b rc=%0d d=%0d want ld=%b bz=%b dn=%b rc=%0d d=%0d",
                 p, l, n, i, a.ld, a.bz, a.dn, a.rc, a.dd,
                 tr[i].ld, tr[i].bz, tr[i].dn, tr[i].rc, tr[i].dd);
      end
      if (busy) busy_cycles++;
      if (done && done_idx < 0) done_idx = i;
      start = (noise && i < tr.size() - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      abort = (i == abort_at);
      if (noise) begin
        preset   = 4'($urandom);
        limit    = 4'($urandom);
        num_runs = 4'($urandom);
      end
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    total++;
    if ({load, busy, done, run_cnt, d} !== 11'd0) begin
      bad++;
      $display("FAIL reset_hold got %b want 0", {load, busy, done, run_cnt, d});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({load, busy, done, run_cnt, d} !== 11'd0) begin
      bad++;
      $display("FAIL reset_idle got %b want 0", {load, busy, done, run_cnt, d});
    end
  endtask

  task automatic test_single();
    int bc, di;
    run_job(9, 12, 1, -1, 1'b0, bc, di);
    total++;
    if (di !== 5 || bc !== 5) begin
      bad++;
      $display("FAIL single done_idx=%0d busy=%0d want 5 5", di, bc);
    end
  endtask

  task automatic test_multi();
    int bc, di;
    run_job(3, 5, 3, -1, 1'b0, bc, di);
    total++;
    if (bc !== 12 || di !== 12) begin
      bad++;
      $display("FAIL multi busy=%0d done_idx=%0d want 12 12", bc, di);
    end
  endtask

  task automatic test_wrap_equal();
    int bc, di;
    run_job(14, 1, 1, -1, 1'b0, bc, di);
    total++;
    if (di !== 5) begin
      bad++;
      $display("FAIL wrap done_idx=%0d want 5", di);
    end
    run_job(7, 7, 1, -1, 1'b0, bc, di);
    total++;
    if (di !== 2) begin
      bad++;
      $display("FAIL equal done_idx=%0d want 2", di);
    end
  endtask

  task automatic test_abort();
    int bc, di;
    run_job(3, 5, 3, 5, 1'b0, bc, di);
    total++;
    if (di !== -1 || run_cnt !== 4'd1) begin
      bad++;
      $display("FAIL abort done_idx=%0d run_cnt=%0d want -1 1", di, run_cnt);
    end
    run_job(3, 5, 2, -1, 1'b0, bc, di);
  endtask

  task automatic test_busy_start_zero_runs();
    int bc, di;
    run_job(5, 9, 2, -1, 1'b1, bc, di);
    run_job(0, 2, 0, -1, 1'b1, bc, di);
    total++;
    if (run_cnt !== 4'd1 || di !== 4) begin
      bad++;
      $display("FAIL zero_runs run_cnt=%0d done_idx=%0d want 1 4", run_cnt, di);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    preset   = 4'd2;
    limit    = 4'd10;
    num_runs = 4'd3;
    start    = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL async_pre busy=%b want 1", busy);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({load, busy, done, run_cnt, d} !== 11'd0) begin
      bad++;
      $display("FAIL async_rst got %b want 0", {load, busy, done, run_cnt, d});
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      total++;
      if ({load, busy, done, run_cnt, d} !== 11'd0) begin
        bad++;
        $display("FAIL async_after got %b want 0", {load, busy, done, run_cnt, d});
      end
    end
  endtask

  task automatic test_random();
    int bc, di, p, l, n, ab, len, sz;
    for (int j = 0; j < 25; j++) begin
      p   = $urandom_range(0, 15);
      l   = $urandom_range(0, 15);
      n   = $urandom_range(0, 4);
      len = ((l - p) & 15) + 1;
      sz  = ((n == 0) ? 1 : n) * (len + 1) + 2;
      ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, sz - 2) : -1;
      run_job(p, l, n, ab, 1'b1, bc, di);
    end
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    preset   = 4'd0;
    limit    = 4'd0;
    num_runs = 4'd0;
    test_reset();
    test_single();
    test_multi();
    test_wrap_equal();
    test_abort();
    test_busy_start_zero_runs();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/counter_preset_ctrl.md
Name: counter_preset_ctrl

Overview:
- Upstream controller for the 4-bit loadable up counter (ports clk, load, d, q; sync load of d when load=1, else q+1 mod 2^WIDTH).
- Accepts a job: preset value, terminal (limit) value and run count. Loads the counter, watches its q until it reaches limit, reloads for each remaining run, then signals completion.
- Sits between the control/register side and the counter; drives the counter's load/d and consumes its q.

Parameters:
WIDTH, 4, counter data width (preset, limit, d, q_in)
RUNS_W, 4, width of run-count input and run counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  job request, sampled only in IDLE
abort  input  1  cancel current job, any state
preset  input  WIDTH  value loaded into counter at each run start
limit  input  WIDTH  terminal value ending each run
num_runs  input  RUNS_W  runs per job; 0 treated as 1
q_in  input  WIDTH  counter q, fed back
load  output  1  counter load strobe (registered)
d  output  WIDTH  counter load data (registered)
busy  output  1  high while job in progress (LOAD or RUN)
done  output  1  one-cycle completion pulse
run_cnt  output  RUNS_W  completed runs in current/last job

Behaviour:
- Reset (async, rst=1): state=IDLE; load=0, d=0, busy=0, done=0, run_cnt=0; captured limit/runs registers 0.
- All outputs registered; no combinational path from inputs to outputs.
- States: IDLE, LOAD, RUN, DONE.
- IDLE: done=0. If start=1 and abort=0 at an edge:
  - capture preset into d, limit into lim_r, max(num_runs,1) into runs_r;
  - run_cnt<=0; go LOAD.
  - start while busy is ignored, with no queuing.
- LOAD: load=1 and busy=1 for exactly one cycle; the counter takes d at the closing edge. Next state is RUN.
- RUN: load=0, busy=1.
  - Each cycle compare q_in==lim_r. First RUN cycle sees q_in==preset, so preset==limit hits immediately.
  - On hit: run_cnt<=run_cnt+1.
    - If run_cnt+1 < runs_r, go LOAD (reload same d).
    - Else go DONE.
  - Counter wraps 2^WIDTH-1 -> 0. A hit always occurs within 2^WIDTH RUN cycles (e.g. preset=14, limit=1: q 14,15,0,1).
- DONE: done=1, busy=0 for one cycle; next state is IDLE. run_cnt holds until the next accepted start.
- abort=1 at an edge in LOAD/RUN/DONE: go IDLE; load<=0, busy<=0, done<=0; run_cnt holds its partial value. Abort has priority over start and over hit. Abort in IDLE has no effect.
- Simultaneous hit and abort: abort wins, and run_cnt does not increment.
- Reset mid-job: immediate return to reset values; no done pulse.
- d is stable across all reloads of a job; preset/limit input changes after capture have no effect until the next start.

Test Plan:
- preset=9, limit=12, num_runs=1, single start pulse: load high 1 cycle with d=9; RUN sees q_in 9,10,11,12; done high exactly 1 cycle, in the cycle after q_in=12; run_cnt=1; busy high LOAD through last RUN cycle.
- preset=3, limit=5, num_runs=3: three load pulses, each followed by q_in 3,4,5; run_cnt steps 1,2,3; one done pulse after the third hit; 12 busy cycles total.
- Wrap and equal cases:
  - preset=14, limit=1: q_in 14,15,0,1 then done.
  - preset=limit=7: hit in the first RUN cycle, done 3 cycles after start accepted.
- abort during RUN after run_cnt=1 of 3: next cycle IDLE, load=0, busy=0, no done pulse, run_cnt=1. A following start is accepted normally and clears run_cnt to 0.
- rst asserted asynchronously mid-RUN (between edges): load, d, busy, done, run_cnt read 0 immediately. Start pulses during busy and num_runs=0 (treated as 1 run) both checked.
